vx_irq_controller: RTL

//  Interrupt controller front end for SIMT-to-scalar thread transfer. Accepts a pull request
//  (wid, tid, ISR PC) from the scalar core and sequences the IRQC state machine that the

---
 rtl/vx_irq_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vx_irq_controller.sv
// -----------------------------------------------------------------------------
// vx_irq_controller
//
// Interrupt controller front end for SIMT-to-scalar thread transfer. The
// scalar core issues a pull request (wid, tid, ISR PC). This block sequences
// the IRQC state machine that the scheduler's thread transfer unit (TTU)
// follows. It captures the warp context the TTU reports, and returns a
// completion status plus the captured PC to the scalar core.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   irq_valid/irq_ready   request handshake (ready only while idle)
//   irq_wid/tid/isr_pc    request fields, sampled only at accept
//   resp_valid/ready      response handshake
//   resp_status/resp_pc   0 OK / 1 NOT_FOUND / 2 TIMEOUT; captured PC when OK
//   state                 exported IRQC state code for the TTU
//   wid/tid               latched target
//   load_PC/tmask/wmask   values the TTU loads into the warp
//   pipeline_drained, thread_found, current_*   TTU status / context (WAIT)
//   ISR_done              TTU saw the ISR exit jump
// -----------------------------------------------------------------------------
module vx_irq_controller #(
    parameter int THREAD_CNT       = 4,
    parameter int WARP_CNT         = 4,
    parameter int WARP_CNT_WIDTH   = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
    parameter int THREAD_CNT_WIDTH = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1,
    parameter int XLEN             = 32,
    parameter int WAIT_TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        irq_valid,
    output logic                        irq_ready,
    input  logic [WARP_CNT_WIDTH-1:0]   irq_wid,
    input  logic [THREAD_CNT_WIDTH-1:0] irq_tid,
    input  logic [XLEN-1:0]             irq_isr_pc,

    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [1:0]                  resp_status,
    output logic [XLEN-1:0]             resp_pc,

    output logic [2:0]                  state,
    output logic [WARP_CNT_WIDTH-1:0]   wid,
    output logic [THREAD_CNT_WIDTH-1:0] tid,
    output logic [XLEN-1:0]             load_PC,
    output logic [THREAD_CNT-1:0]       load_tmask,
    output logic [WARP_CNT-1:0]         load_wmask,

    input  logic                        pipeline_drained,
    input  logic                        thread_found,
    input  logic [THREAD_CNT-1:0]       current_thread_mask,
    input  logic [XLEN-1:0]             current_PC,
    input  logic [WARP_CNT-1:0]         current_active_warps,
    input  logic                        ISR_done
);

    // Exported IRQC state codes seen by the TTU.
    localparam logic [2:0] IRQC_IDLE = 3'd0;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_NOT_FOUND = 2'd1;
    localparam logic [1:0] ST_TIMEOUT   = 2'd2;

    // Counter wide enough to reach WAIT_TIMEOUT.
    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(WAIT_TIMEOUT);
    localparam bit TIMEOUT_EN = (WAIT_TIMEOUT != 0);

    // Internal encodings 0..4 match the exported IRQC codes; RESP is
    // internal only and is exported as IRQC_IDLE.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT        = 3'd1,
        S_PC_SWAP     = 3'd2,
        S_WAIT_ISR    = 3'd3,
        S_REVERT_WARP = 3'd4,
        S_RESP        = 3'd5
    } fsm_t;

    fsm_t                        fsm_reg;
    logic                        irq_ready_reg;
    logic                        resp_valid_reg;
    logic [1:0]                  resp_status_reg;
    logic [XLEN-1:0]             resp_pc_reg;
    logic [WARP_CNT_WIDTH-1:0]   wid_reg;
    logic [THREAD_CNT_WIDTH-1:0] tid_reg;
    logic [XLEN-1:0]             load_pc_reg;
    logic [THREAD_CNT-1:0]       load_tmask_reg;
    logic [WARP_CNT-1:0]         load_wmask_reg;
    logic [THREAD_CNT-1:0]       saved_tmask_reg;
    logic [XLEN-1:0]             saved_pc_reg;
    logic [WARP_CNT-1:0]         saved_wmask_reg;
    logic [CNT_W-1:0]            wait_cnt_reg;
    logic [CNT_W-1:0]            wait_cnt_next;

    assign wait_cnt_next = wait_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg         <= S_IDLE;
            irq_ready_reg   <= 1'b1;
            resp_valid_reg  <= 1'b0;
            resp_status_reg <= ST_OK;
            resp_pc_reg     <= '0;
            wid_reg         <= '0;
            tid_reg         <= '0;
            load_pc_reg     <= '0;
            load_tmask_reg  <= '0;
            load_wmask_reg  <= '0;
            saved_tmask_reg <= '0;
            saved_pc_reg    <= '0;
            saved_wmask_reg <= '0;
            wait_cnt_reg    <= '0;
        end else begin
            case (fsm_reg)
                S_IDLE: begin
                    if (irq_valid) begin
                        wid_reg       <= irq_wid;
                        tid_reg       <= irq_tid;
                        load_pc_reg   <= irq_isr_pc;  // held through WAIT_ISR for the TTU compare
                        wait_cnt_reg  <= '0;
                        irq_ready_reg <= 1'b0;
                        fsm_reg       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A drained pipeline always wins over an expiring timeout.
                    if (pipeline_drained) begin
                        if (thread_found) begin
                            saved_tmask_reg <= current_thread_mask;
                            saved_pc_reg    <= current_PC;
                            saved_wmask_reg <= current_active_warps;
                            fsm_reg         <= S_PC_SWAP;
                        end else begin
                            resp_status_reg <= ST_NOT_FOUND;
                            resp_pc_reg     <= '0;
                            resp_valid_reg  <= 1'b1;
                            load_pc_reg     <= '0;
                            fsm_reg         <= S_RESP;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (TIMEOUT_EN && (wait_cnt_next == TIMEOUT_VAL)) begin
                            resp_status_reg <= ST_TIMEOUT;
                            resp_pc_reg     <= '0;
                            resp_valid_reg  <= 1'b1;
                            load_pc_reg     <= '0;
                            fsm_reg         <= S_RESP;
                        end
                    end
                end
                S_PC_SWAP: begin
                    fsm_reg <= S_WAIT_ISR;
                end
                S_WAIT_ISR: begin
                    if (ISR_done) begin
                        load_pc_reg     <= saved_pc_reg;
                        load_tmask_reg  <= saved_tmask_reg;
                        load_wmask_reg  <= saved_wmask_reg;
                        resp_status_reg <= ST_OK;
                        resp_pc_reg     <= saved_pc_reg;
                        fsm_reg         <= S_REVERT_WARP;
                    end
                end
                S_REVERT_WARP: begin
                    // Restore values are only presented for this single cycle.
                    load_pc_reg    <= '0;
                    load_tmask_reg <= '0;
                    load_wmask_reg <= '0;
                    resp_valid_reg <= 1'b1;
                    fsm_reg        <= S_RESP;
                end
                S_RESP: begin
                    // irq_ready rises only after the handshake cycle, so a
                    // new request cannot be taken in that same cycle.
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        irq_ready_reg  <= 1'b1;
                        fsm_reg        <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid_reg <= 1'b0;
                    irq_ready_reg  <= 1'b1;
                    fsm_reg        <= S_IDLE;
                end
            endcase
        end
    end

    assign state       = (fsm_reg == S_RESP) ? IRQC_IDLE : 3'(fsm_reg);
    assign irq_ready   = irq_ready_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_status = resp_status_reg;
    assign resp_pc     = resp_pc_reg;
    assign wid         = wid_reg;
    assign tid         = tid_reg;
    assign load_PC     = load_pc_reg;
    assign load_tmask  = load_tmask_reg;
    assign load_wmask  = load_wmask_reg;

endmodule
